// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
//   Runs one multi-cycle multiply or divide at a time between the execute stage
//   and the multdiv unit.
//   - On accept it latches the operands, the destination register and the
//     operation type.
//   - It then sends a one-cycle start pulse and stalls the pipeline until
//     multdiv reports a result.
//   - Finally it offers the result, or an rstatus exception code, on a
//     valid/ready writeback port.
//
// Optional build macro:
//   MD_TIMEOUT_EN - Abort a BUSY wait after TIMEOUT_CYCLES cycles with no
//                   result, and report it as the op's exception.
//
// Ports:
//   clock, reset              Rising-edge clock; synchronous active-high reset.
//   issue_valid, is_mult,     Execute-stage request. is_mult wins if both op
//   is_div                    flags are high.
//   opA, opB, dest_reg        Operands and destination register of the request.
//   flush                     Kill any in-flight op. Also blocks an accept in
//                             the same cycle.
//   md_operandA, md_operandB  Registered operands to multdiv.
//   md_ctrl_MULT, md_ctrl_DIV One-cycle start pulses to multdiv.
//   md_result, md_exception,  Result interface from multdiv.
//   md_resultRDY
//   stall                     Combinational freeze of the upstream pipeline.
//   wb_valid, wb_ready        Writeback handshake.
//   wb_reg, wb_data,          Writeback payload. It is held stable while
//   wb_exception              wb_valid is high.
module multdiv_issue_ctrl #(
    parameter int unsigned RSTATUS_REG    = 30,
    parameter int unsigned MULT_EXC_CODE  = 4,
    parameter int unsigned DIV_EXC_CODE   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  dest_reg,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    state_e      state_q;
    logic        op_mult_q;
    logic [4:0]  dest_q;
    logic        accept;
    logic [31:0] exc_code;

`ifdef MD_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] busy_cnt_q;
`endif

    assign accept   = issue_valid & (is_mult | is_div) & ~flush;
    assign exc_code = op_mult_q ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE);

    // stall drops in the cycle the writeback is accepted, so the pipeline advances then.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            StIdle:  stall = accept;
            StStart: stall = 1'b1;
            StBusy:  stall = 1'b1;
            StDone:  stall = ~wb_ready;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            op_mult_q    <= 1'b0;
            dest_q       <= 5'd0;
            md_operandA  <= 32'd0;
            md_operandB  <= 32'd0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= 32'd0;
            wb_exception <= 1'b0;
`ifdef MD_TIMEOUT_EN
            busy_cnt_q   <= '0;
`endif
        end else begin
            // Start pulses last exactly one cycle (the START state).
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            if (flush && state_q != StIdle) begin
                state_q  <= StIdle;
                wb_valid <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            md_operandA  <= opA;
                            md_operandB  <= opB;
                            dest_q       <= dest_reg;
                            op_mult_q    <= is_mult;
                            md_ctrl_MULT <= is_mult;
                            md_ctrl_DIV  <= ~is_mult;
                            state_q      <= StStart;
                        end
                    end
                    StStart: begin
`ifdef MD_TIMEOUT_EN
                        busy_cnt_q <= '0;
`endif
                        state_q <= StBusy;
                    end
                    StBusy: begin
                        // RDY is only sampled here, so stale RDY elsewhere is harmless.
                        if (md_resultRDY) begin
                            if (md_exception) begin
                                wb_reg       <= 5'(RSTATUS_REG);
                                wb_data      <= exc_code;
                                wb_exception <= 1'b1;
                                wb_valid     <= 1'b1;
                                state_q      <= StDone;
                            end else if (dest_q != 5'd0) begin
                                wb_reg       <= dest_q;
                                wb_data      <= md_result;
                                wb_exception <= 1'b0;
                                wb_valid     <= 1'b1;
                                state_q      <= StDone;
                            end else begin
                                // Writes to r0 are dropped without a writeback.
                                state_q <= StIdle;
                            end
                        end
`ifdef MD_TIMEOUT_EN
                        else if (busy_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                            wb_reg       <= 5'(RSTATUS_REG);
                            wb_data      <= exc_code;
                            wb_exception <= 1'b1;
                            wb_valid     <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            busy_cnt_q <= busy_cnt_q + 1'b1;
                        end
`endif
                    end
                    StDone: begin
                        if (wb_ready) begin
                            wb_valid <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl.
// The expected writeback for each op comes from an operation-level model of
// multdiv plus the controller's timing rules:
//   - accept at cycle 0;
//   - start pulse at cycle 1;
//   - RDY at 1 + delay;
//   - writeback on the following cycles until it is accepted.
module tb_multdiv_issue_ctrl;

    localparam int unsigned RSTATUS = 30;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, is_mult, is_div, flush;
    logic [31:0] opA, opB, md_result;
    logic [4:0]  dest_reg;
    logic        md_exception, md_resultRDY, wb_ready;
    logic [31:0] md_operandA, md_operandB, wb_data;
    logic        md_ctrl_MULT, md_ctrl_DIV, stall, wb_valid, wb_exception;
    logic [4:0]  wb_reg;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    multdiv_issue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .is_mult      (is_mult),
        .is_div       (is_div),
        .opA          (opA),
        .opB          (opB),
        .dest_reg     (dest_reg),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_exception (wb_exception)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Quiet inputs; data buses carry random junk that must be ignored.
    task automatic idle_inputs();
        issue_valid  = 1'b0;
        is_mult      = 1'b0;
        is_div       = 1'b0;
        flush        = 1'b0;
        wb_ready     = 1'b0;
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        md_result    = $urandom;
        opA          = $urandom;
        opB          = $urandom;
        dest_reg     = 5'($urandom);
    endtask

    // Behaviour of the multdiv unit: signed multiply overflow, divide-by-zero.
    task automatic md_model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output bit exc);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        if (mult) begin
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else begin
            exc = (b == 32'd0);
            res = exc ? 32'd0 : a / b;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "_ctrl"}, 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    endtask

    // One complete operation. flush_at is the cycle index (1 = START) that
    // raises flush, or -1 for none.
    task automatic run_op(input bit mult, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input int rdy_dly,
                          input int ready_dly, input int flush_at);
        logic [31:0] res, exp_data;
        logic [4:0]  exp_reg;
        bit          exc, writes, as_mult;
        int          t_rdy, t_end;
        as_mult = mult | both;
        md_model(as_mult, a, b, res, exc);
        writes   = exc || (d != 5'd0);
        exp_reg  = exc ? 5'(RSTATUS) : d;
        exp_data = exc ? (as_mult ? 32'd4 : 32'd5) : res;
        t_rdy    = 1 + rdy_dly;
        t_end    = writes ? t_rdy + 1 + ready_dly : t_rdy;

        @(negedge clock);
        idle_inputs();
        issue_valid = 1'b1;
        is_mult     = as_mult;
        is_div      = ~mult | both;
        opA         = a;
        opB         = b;
        dest_reg    = d;
        #1;
        check_eq("accept_stall", 32'(stall), 32'd1);
        check_eq("accept_wb_valid", 32'(wb_valid), 32'd0);

        for (int t = 1; t <= t_end; t++) begin
            @(negedge clock);
            idle_inputs();
            if (t == t_rdy) begin
                md_resultRDY = 1'b1;
                md_result    = res;
                md_exception = exc;
            end else if (t == 1 || t > t_rdy) begin
                md_resultRDY = 1'($urandom);
                md_exception = 1'($urandom);
            end
            if (t > t_rdy) wb_ready = (t == t_end);
            if (t == flush_at) flush = 1'b1;
            #1;
            check_eq("ctrl_mult", 32'(md_ctrl_MULT), 32'(t == 1 && as_mult));
            check_eq("ctrl_div", 32'(md_ctrl_DIV), 32'(t == 1 && !as_mult));
            check_eq("operand_a", md_operandA, a);
            check_eq("operand_b", md_operandB, b);
            if (t <= t_rdy) begin
                check_eq("busy_stall", 32'(stall), 32'd1);
                check_eq("busy_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                check_eq("wb_valid", 32'(wb_valid), 32'd1);
                check_eq("wb_reg", 32'(wb_reg), 32'(exp_reg));
                check_eq("wb_data", wb_data, exp_data);
                check_eq("wb_exception", 32'(wb_exception), 32'(exc));
                check_eq("done_stall", 32'(stall), 32'(!wb_ready));
            end
            if (t == flush_at) break;
        end

        @(negedge clock);
        idle_inputs();
        #1;
        check_quiet("after_op");
        if (flush_at >= 1 && flush_at <= t_end) begin
            // A late RDY from the killed op must not produce a writeback.
            @(negedge clock);
            idle_inputs();
            md_resultRDY = 1'b1;
            md_exception = 1'($urandom);
            #1;
            check_quiet("stray_rdy");
            @(negedge clock);
            idle_inputs();
            #1;
            check_quiet("post_stray");
        end
    endtask

`ifdef MD_TIMEOUT_EN
    task automatic timeout_op();
        @(negedge clock);
        idle_inputs();
        issue_valid = 1'b1;
        is_mult     = 1'b1;
        dest_reg    = 5'd4;
        for (int t = 1; t <= 42; t++) begin
            @(negedge clock);
            idle_inputs();
            if (t == 42) wb_ready = 1'b1;
            #1;
            if (t <= 41) begin
                check_eq("to_busy_wb_valid", 32'(wb_valid), 32'd0);
                check_eq("to_busy_stall", 32'(stall), 32'd1);
            end else begin
                check_eq("to_wb_valid", 32'(wb_valid), 32'd1);
                check_eq("to_wb_reg", 32'(wb_reg), RSTATUS);
                check_eq("to_wb_data", wb_data, 32'd4);
                check_eq("to_wb_exception", 32'(wb_exception), 32'd1);
            end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        check_quiet("to_after");
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_quiet("reset");
        check_eq("reset_opa", md_operandA, 32'd0);
        check_eq("reset_wb_reg", 32'(wb_reg), 32'd0);
        check_eq("reset_wb_data", wb_data, 32'd0);
        check_eq("reset_wb_exc", 32'(wb_exception), 32'd0);
        reset = 1'b0;

        // Directed cases.
        run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 17, 0, -1);
        run_op(1'b0, 1'b0, 32'd100, 32'd0, 5'd5, 4, 0, -1);
        run_op(1'b1, 1'b0, 32'h10000, 32'h10000, 5'd8, 3, 3, -1);
        run_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd0, 5, 0, -1);
        run_op(1'b1, 1'b0, 32'd11, 32'd12, 5'd6, 8, 0, 4);
        run_op(1'b0, 1'b0, 32'd99, 32'd7, 5'd2, 3, 1, -1);
        run_op(1'b0, 1'b1, 32'd5, 32'd5, 5'd1, 2, 0, -1);
        run_op(1'b0, 1'b0, 32'd50, 32'd3, 5'd7, 2, 2, 4);

        // Flush in IDLE blocks the accept.
        @(negedge clock);
        idle_inputs();
        issue_valid = 1'b1;
        is_mult     = 1'b1;
        flush       = 1'b1;
        #1;
        check_eq("flush_idle_stall", 32'(stall), 32'd0);
        @(negedge clock);
        idle_inputs();
        #1;
        check_quiet("flush_idle_next");

        // Reset in the middle of BUSY, with RDY arriving alongside it.
        @(negedge clock);
        idle_inputs();
        issue_valid = 1'b1;
        is_mult     = 1'b1;
        dest_reg    = 5'd9;
        repeat (4) begin
            @(negedge clock);
            idle_inputs();
        end
        reset        = 1'b1;
        md_resultRDY = 1'b1;
        @(negedge clock);
        idle_inputs();
        #1;
        check_quiet("mid_reset");
        check_eq("mid_reset_opa", md_operandA, 32'd0);
        check_eq("mid_reset_wb_data", wb_data, 32'd0);
        check_eq("mid_reset_wb_reg", 32'(wb_reg), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        idle_inputs();
        md_resultRDY = 1'b1;
        #1;
        check_quiet("post_reset");

`ifdef MD_TIMEOUT_EN
        timeout_op();
`else
        run_op(1'b1, 1'b0, 32'd3, 32'd5, 5'd7, 45, 0, -1);
`endif

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            bit          m;
            logic [31:0] a, b;
            logic [4:0]  d;
            int          rd, rr, fa;
            m = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (m && $urandom_range(0, 1) == 0) begin
                a = a & 32'h7fff;
                b = b & 32'h7fff;
            end
            if (!m && $urandom_range(0, 3) == 0) b = 32'd0;
            d = 5'($urandom);
            if ($urandom_range(0, 4) == 0) d = 5'd0;
            rd = $urandom_range(1, 20);
            rr = $urandom_range(0, 3);
            fa = -1;
            if ($urandom_range(0, 5) == 0) fa = $urandom_range(1, rd);
            else if ($urandom_range(0, 7) == 0) fa = rd + 2;
            run_op(m, 1'b0, a, b, d, rd, rr, fa);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
